// File: rtl/io_pkg.sv
// Shared constants and helpers for the memory-mapped I/O bank.
//   IO_WIDTH / IO_NPORTS : default port width and port count, reused by the CPU top.
//   ARM_MAX              : value at which the change-detect arm counter saturates.
//   mask_addr/pend_addr  : register offsets that follow the port data addresses.
package io_pkg;

  localparam int unsigned IO_WIDTH  = 8;
  localparam int unsigned IO_NPORTS = 4;
  localparam int unsigned ARM_MAX   = 3;

  typedef logic [1:0] arm_t;

  function automatic int unsigned mask_addr(input int unsigned nports);
    return nports;
  endfunction

  function automatic int unsigned pend_addr(input int unsigned nports);
    return nports + 1;
  endfunction

endpackage

// File: rtl/io_sync.sv
// WIDTH-bit two-flop synchroniser with asynchronous active-high reset.
//   clk   : sampling clock
//   reset : asynchronous, active-high; clears both stages
//   d_i   : asynchronous input
//   q_o   : synchronised output (two rising edges of latency)
module io_sync #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_d, meta_q;
  logic [WIDTH-1:0] sync_d, sync_q;

  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/io_bank.sv
// Parametrised memory-mapped I/O bank: NPORTS synchronised inputs, NPORTS registered outputs
// with a one-cycle write strobe per port, and optional change-detect interrupts.
//   clk, reset : rising-edge clock, asynchronous active-high reset
//   addr       : CPU register address (0..NPORTS-1 data, NPORTS mask, NPORTS+1 pending)
//   wr_en      : write strobe, wdata committed on the next rising edge
//   wdata      : CPU write data
//   rdata      : combinational read data for addr
//   in_p       : input pins, port i at [i*WIDTH +: WIDTH]
//   out_p      : registered output ports, same packing
//   out_stb    : per-port pulse in the cycle after that port is written
//   irq        : OR over ports of (pending & mask)
// Build option: define IO_IRQ_EN to generate the change-detect interrupt logic; without it
// irq is tied low and the mask/pending addresses read as zero and ignore writes.
module io_bank
  import io_pkg::*;
#(
  parameter int unsigned WIDTH  = IO_WIDTH,
  parameter int unsigned NPORTS = IO_NPORTS,
  parameter int unsigned AW     = $clog2(NPORTS) + 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [AW-1:0]           addr,
  input  logic                    wr_en,
  input  logic [WIDTH-1:0]        wdata,
  output logic [WIDTH-1:0]        rdata,
  input  logic [NPORTS*WIDTH-1:0] in_p,
  output logic [NPORTS*WIDTH-1:0] out_p,
  output logic [NPORTS-1:0]       out_stb,
  output logic                    irq
);

  localparam int unsigned FW = NPORTS * WIDTH;

  logic [FW-1:0]     in_q;
  logic [NPORTS-1:0] wr_port;
  logic [FW-1:0]     out_d, out_q;
  logic [NPORTS-1:0] out_stb_d, out_stb_q;

  for (genvar i = 0; i < NPORTS; i++) begin : g_sync
    io_sync #(
      .WIDTH(WIDTH)
    ) u_sync (
      .clk  (clk),
      .reset(reset),
      .d_i  (in_p[i*WIDTH +: WIDTH]),
      .q_o  (in_q[i*WIDTH +: WIDTH])
    );
  end

  // Data-port write decode.
  always_comb begin
    wr_port = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (wr_en && (addr == AW'(i))) wr_port[i] = 1'b1;
    end
  end

  always_comb begin
    out_d = out_q;
    for (int i = 0; i < NPORTS; i++) begin
      if (wr_port[i]) out_d[i*WIDTH +: WIDTH] = wdata;
    end
    out_stb_d = wr_port;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_q     <= '0;
      out_stb_q <= '0;
    end else begin
      out_q     <= out_d;
      out_stb_q <= out_stb_d;
    end
  end

  assign out_p   = out_q;
  assign out_stb = out_stb_q;

`ifdef IO_IRQ_EN
  localparam logic [AW-1:0] MaskAddr = AW'(mask_addr(NPORTS));
  localparam logic [AW-1:0] PendAddr = AW'(pend_addr(NPORTS));

  logic [FW-1:0]     in_prev_d, in_prev_q;
  logic [NPORTS-1:0] mask_d, mask_q;
  logic [NPORTS-1:0] pend_d, pend_q;
  logic [NPORTS-1:0] changed;
  arm_t              arm_d, arm_q;
  logic              armed;

  always_comb begin
    in_prev_d = in_q;
    // Detection stays off until the synchronisers have flushed their reset zeros.
    armed = (arm_q == arm_t'(ARM_MAX));
    arm_d = armed ? arm_q : arm_q + arm_t'(1);
    for (int i = 0; i < NPORTS; i++) begin
      changed[i] = (in_q[i*WIDTH +: WIDTH] != in_prev_q[i*WIDTH +: WIDTH]);
    end
    mask_d = (wr_en && (addr == MaskAddr)) ? wdata[NPORTS-1:0] : mask_q;
    pend_d = pend_q;
    if (wr_en && (addr == PendAddr)) pend_d = pend_d & ~wdata[NPORTS-1:0];
    // Applied after the clear so a simultaneous new change keeps the bit set.
    if (armed) pend_d = pend_d | changed;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_prev_q <= '0;
      mask_q    <= '0;
      pend_q    <= '0;
      arm_q     <= '0;
    end else begin
      in_prev_q <= in_prev_d;
      mask_q    <= mask_d;
      pend_q    <= pend_d;
      arm_q     <= arm_d;
    end
  end

  assign irq = |(pend_q & mask_q);
`else
  assign irq = 1'b0;
`endif

  always_comb begin
    rdata = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (addr == AW'(i)) rdata = in_q[i*WIDTH +: WIDTH];
    end
`ifdef IO_IRQ_EN
    if (addr == MaskAddr) rdata[NPORTS-1:0] = mask_q;
    if (addr == PendAddr) rdata[NPORTS-1:0] = pend_q;
`endif
  end

endmodule
